// File: rtl/fft_pkg.sv
// fft_pkg: shared definitions for the iterative radix-2 FFT core.
//   - FSM state encodings (LOAD / COMPUTE / UNLOAD)
//   - width limits for the supported transform lengths
//   - bitrev(): bit-reversal of an index over a given number of bits
//   - twiddle_re()/twiddle_im(): forward twiddle W = e^-j2πk/N scaled by
//     2^(tw-2) and rounded to nearest; evaluated at elaboration only.
package fft_pkg;

    localparam logic [1:0] ST_LOAD    = 2'd0;
    localparam logic [1:0] ST_COMPUTE = 2'd1;
    localparam logic [1:0] ST_UNLOAD  = 2'd2;

    localparam int MAX_N     = 1024;
    localparam int MAX_LOG2N = $clog2(MAX_N);
    localparam int BR_W      = 16;

    // Reverse the low 'bits' bits of idx; higher bits of the result are zero.
    function automatic logic [BR_W-1:0] bitrev(input logic [BR_W-1:0] idx, input int bits);
        logic [BR_W-1:0] r;
        r = '0;
        for (int i = 0; i < BR_W; i++) begin
            if (i < bits) begin
                r = r | (((idx >> i) & BR_W'(1)) << (bits - 1 - i));
            end
        end
        return r;
    endfunction

    function automatic int round_real(input real x);
        if (x >= 0.0) begin
            return $rtoi(x + 0.5);
        end
        return -$rtoi(0.5 - x);
    endfunction

    function automatic int twiddle_re(input int k, input int n, input int tw);
        real ang;
        real amp;
        ang = 6.283185307179586 * real'(k) / real'(n);
        amp = real'(1 << (tw - 2));
        return round_real($cos(ang) * amp);
    endfunction

    // Forward direction: imaginary part of e^-jθ is -sin θ.
    function automatic int twiddle_im(input int k, input int n, input int tw);
        real ang;
        real amp;
        ang = 6.283185307179586 * real'(k) / real'(n);
        amp = real'(1 << (tw - 2));
        return round_real(-$sin(ang) * amp);
    endfunction

endpackage

// File: rtl/fft_bfly.sv
// fft_bfly: radix-2 DIT butterfly, two register stages, latency 2.
//   x = a + b*W, y = a - b*W (W conjugated when inverse=1).
//   Product is full precision, rounded by TW-2 bits; sums are formed wide,
//   optionally halved with round-half-up (scale=1), then saturated to DW.
// Ports:
//   clk            rising-edge clock
//   inverse, scale frame-constant mode controls
//   a_*, b_*       DW-bit signed operands
//   w_*            TW-bit signed forward twiddle
//   x_*, y_*       DW-bit signed results (registered)
//   sat            any of the four results was clipped (registered, aligned with x/y)
module fft_bfly #(
    parameter int DW = 8,
    parameter int TW = 8
) (
    input  logic                 clk,
    input  logic                 inverse,
    input  logic                 scale,
    input  logic signed [DW-1:0] a_re,
    input  logic signed [DW-1:0] a_im,
    input  logic signed [DW-1:0] b_re,
    input  logic signed [DW-1:0] b_im,
    input  logic signed [TW-1:0] w_re,
    input  logic signed [TW-1:0] w_im,
    output logic signed [DW-1:0] x_re,
    output logic signed [DW-1:0] x_im,
    output logic signed [DW-1:0] y_re,
    output logic signed [DW-1:0] y_im,
    output logic                 sat
);

    localparam int PW = DW + TW + 1;
    localparam int SW = PW + 1;
    localparam logic signed [PW-1:0] RND  = PW'(1) <<< (TW - 3);
    localparam logic signed [SW-1:0] MAXV = SW'((1 << (DW - 1)) - 1);
    localparam logic signed [SW-1:0] MINV = SW'(-(1 << (DW - 1)));

    function automatic logic signed [PW-1:0] round_prod(input logic signed [PW-1:0] p);
        return (p + RND) >>> (TW - 2);
    endfunction

    function automatic logic signed [SW-1:0] scale_sum(input logic signed [SW-1:0] v, input logic en);
        return en ? ((v + SW'(1)) >>> 1) : v;
    endfunction

    function automatic logic signed [DW-1:0] sat_val(input logic signed [SW-1:0] v);
        if (v > MAXV) begin
            return DW'(MAXV);
        end
        if (v < MINV) begin
            return DW'(MINV);
        end
        return DW'(v);
    endfunction

    function automatic logic sat_hit(input logic signed [SW-1:0] v);
        return (v > MAXV) || (v < MINV);
    endfunction

    logic signed [TW-1:0] w_im_c;
    logic signed [PW-1:0] prod_re_p0, prod_im_p0;
    logic signed [PW-1:0] prod_re_p1, prod_im_p1;
    logic signed [DW-1:0] a_re_p1, a_im_p1;
    logic signed [PW-1:0] t_re, t_im;
    logic signed [SW-1:0] s_re, s_im, d_re, d_im;

    // ---- stage p0: complex multiply b*W (full precision) ----
    always_comb begin
        w_im_c     = inverse ? -w_im : w_im;
        prod_re_p0 = PW'(b_re) * PW'(w_re) - PW'(b_im) * PW'(w_im_c);
        prod_im_p0 = PW'(b_re) * PW'(w_im_c) + PW'(b_im) * PW'(w_re);
    end

    // ---- stage p1: registered product and delayed a ----
    always_ff @(posedge clk) begin
        prod_re_p1 <= prod_re_p0;
        prod_im_p1 <= prod_im_p0;
        a_re_p1    <= a_re;
        a_im_p1    <= a_im;
    end

    always_comb begin
        t_re = round_prod(prod_re_p1);
        t_im = round_prod(prod_im_p1);
        s_re = scale_sum(SW'(a_re_p1) + SW'(t_re), scale);
        s_im = scale_sum(SW'(a_im_p1) + SW'(t_im), scale);
        d_re = scale_sum(SW'(a_re_p1) - SW'(t_re), scale);
        d_im = scale_sum(SW'(a_im_p1) - SW'(t_im), scale);
    end

    // ---- stage p2: saturated results ----
    always_ff @(posedge clk) begin
        x_re <= sat_val(s_re);
        x_im <= sat_val(s_im);
        y_re <= sat_val(d_re);
        y_im <= sat_val(d_im);
        sat  <= sat_hit(s_re) | sat_hit(s_im) | sat_hit(d_re) | sat_hit(d_im);
    end

endmodule

// File: rtl/fft_iter_core.sv
// fft_iter_core: in-place iterative radix-2 DIT FFT/IFFT, one frame at a time.
//   LOAD    accepts N samples, stored at bit-reversed addresses.
//   COMPUTE runs log2(N) stages of N/2 butterflies plus 2 drain cycles each.
//   UNLOAD  streams X[0..N-1] in natural order through registered outputs.
// Ports:
//   clk1                   clock, rising edge
//   rst                    asynchronous reset, active LOW
//   in_valid/in_ready      input handshake (ready only in LOAD)
//   in_re, in_im           input sample
//   inverse, scale         mode, sampled on the first beat of a frame
//   out_valid/out_ready    output handshake
//   out_re, out_im         output bin value
//   out_idx, out_last      bin index, high on the final bin
//   ovf                    saturation seen in the current frame
module fft_iter_core
    import fft_pkg::*;
#(
    parameter int N  = 32,
    parameter int DW = 8,
    parameter int TW = 8
) (
    input  logic                    clk1,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [DW-1:0]    in_re,
    input  logic signed [DW-1:0]    in_im,
    input  logic                    inverse,
    input  logic                    scale,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [DW-1:0]    out_re,
    output logic signed [DW-1:0]    out_im,
    output logic [$clog2(N)-1:0]    out_idx,
    output logic                    out_last,
    output logic                    ovf
);

    localparam int LW    = $clog2(N);
    localparam int S     = LW;
    localparam int HALF  = N / 2;
    localparam int TWI_W = LW - 1;

    logic [1:0]            state;
    logic [LW-1:0]         n_cnt, cnt, stg, rd_k;
    logic                  inv_q, scl_q;
    logic                  accept;
    logic [LW-1:0]         n_rev;

    logic signed [DW-1:0]  mem_re [N];
    logic signed [DW-1:0]  mem_im [N];
    logic signed [TW-1:0]  rom_re [HALF];
    logic signed [TW-1:0]  rom_im [HALF];

    logic                  vld_p0, vld_p1, vld_p2;
    logic [LW-1:0]         hmask, off_p0, a_addr_p0, b_addr_p0;
    logic [TWI_W-1:0]      tw_idx_p0;
    logic [LW-1:0]         a_addr_p1, b_addr_p1, a_addr_p2, b_addr_p2;
    logic signed [DW-1:0]  sum_re_p2, sum_im_p2, dif_re_p2, dif_im_p2;
    logic                  sat_p2;

    for (genvar k = 0; k < HALF; k++) begin : g_rom
        localparam logic signed [TW-1:0] WR = TW'(twiddle_re(k, N, TW));
        localparam logic signed [TW-1:0] WI = TW'(twiddle_im(k, N, TW));
        assign rom_re[k] = WR;
        assign rom_im[k] = WI;
    end

    assign in_ready = (state == ST_LOAD);
    assign accept   = in_valid && in_ready;
    assign n_rev    = LW'(bitrev(BR_W'(n_cnt), LW));

    // ---- stage p0: butterfly address generation and RAM read ----
    // Span h = 2^stg: a = grp*2h + off, b = a + h, twiddle index off*N/(2h).
    always_comb begin
        vld_p0    = (state == ST_COMPUTE) && (cnt < LW'(HALF));
        hmask     = (LW'(1) << stg) - LW'(1);
        off_p0    = cnt & hmask;
        a_addr_p0 = ((cnt >> stg) << (stg + LW'(1))) | off_p0;
        b_addr_p0 = a_addr_p0 | (LW'(1) << stg);
        tw_idx_p0 = TWI_W'(off_p0 << (LW'(LW - 1) - stg));
    end

    fft_bfly #(
        .DW (DW),
        .TW (TW)
    ) u_bfly (
        .clk     (clk1),
        .inverse (inv_q),
        .scale   (scl_q),
        .a_re    (mem_re[a_addr_p0]),
        .a_im    (mem_im[a_addr_p0]),
        .b_re    (mem_re[b_addr_p0]),
        .b_im    (mem_im[b_addr_p0]),
        .w_re    (rom_re[tw_idx_p0]),
        .w_im    (rom_im[tw_idx_p0]),
        .x_re    (sum_re_p2),
        .x_im    (sum_im_p2),
        .y_re    (dif_re_p2),
        .y_im    (dif_im_p2),
        .sat     (sat_p2)
    );

    // ---- stages p1/p2: address delay matching the butterfly latency ----
    always_ff @(posedge clk1) begin
        a_addr_p1 <= a_addr_p0;
        b_addr_p1 <= b_addr_p0;
        a_addr_p2 <= a_addr_p1;
        b_addr_p2 <= b_addr_p1;
    end

    // Loads and write-backs never coincide: they belong to different states.
    always_ff @(posedge clk1) begin
        if (accept) begin
            mem_re[n_rev] <= in_re;
            mem_im[n_rev] <= in_im;
        end
        if (vld_p2) begin
            mem_re[a_addr_p2] <= sum_re_p2;
            mem_im[a_addr_p2] <= sum_im_p2;
            mem_re[b_addr_p2] <= dif_re_p2;
            mem_im[b_addr_p2] <= dif_im_p2;
        end
    end

    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            state     <= ST_LOAD;
            n_cnt     <= '0;
            cnt       <= '0;
            stg       <= '0;
            rd_k      <= '0;
            inv_q     <= 1'b0;
            scl_q     <= 1'b0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_idx   <= '0;
            out_re    <= '0;
            out_im    <= '0;
            ovf       <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;

            if (accept && n_cnt == '0) begin
                inv_q <= inverse;
                scl_q <= scale;
                ovf   <= 1'b0;
            end else if (vld_p2 && sat_p2) begin
                ovf <= 1'b1;
            end

            case (state)
                ST_LOAD: begin
                    if (accept) begin
                        if (n_cnt == LW'(N - 1)) begin
                            n_cnt <= '0;
                            state <= ST_COMPUTE;
                        end else begin
                            n_cnt <= n_cnt + LW'(1);
                        end
                    end
                end
                ST_COMPUTE: begin
                    if (cnt == LW'(HALF + 1)) begin
                        cnt <= '0;
                        if (stg == LW'(S - 1)) begin
                            stg   <= '0;
                            state <= ST_UNLOAD;
                        end else begin
                            stg <= stg + LW'(1);
                        end
                    end else begin
                        cnt <= cnt + LW'(1);
                    end
                end
                ST_UNLOAD: begin
                    // First UNLOAD cycle primes the output register with X[0].
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_re    <= mem_re[0];
                        out_im    <= mem_im[0];
                        out_idx   <= '0;
                        out_last  <= 1'b0;
                        rd_k      <= LW'(1);
                    end else if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_idx   <= '0;
                            rd_k      <= '0;
                            state     <= ST_LOAD;
                        end else begin
                            out_re   <= mem_re[rd_k];
                            out_im   <= mem_im[rd_k];
                            out_idx  <= rd_k;
                            out_last <= (rd_k == LW'(N - 1));
                            rd_k     <= rd_k + LW'(1);
                        end
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_iter_core.sv
module tb_fft_iter_core;

    localparam int N   = 32;
    localparam int DW  = 8;
    localparam int TW  = 8;
    localparam int LAT = 91;

    logic                 clk1 = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_re, in_im;
    logic                 inverse, scale;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_re, out_im;
    logic [4:0]           out_idx;
    logic                 out_last;
    logic                 ovf;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int t_last;
    int x_re [N];
    int x_im [N];
    int e_re [N];
    int e_im [N];
    int got_re [N];
    int got_im [N];
    int cos_tab [N];

    fft_iter_core #(.N(N), .DW(DW), .TW(TW)) dut (
        .clk1      (clk1),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .inverse   (inverse),
        .scale     (scale),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .ovf       (ovf)
    );

    always #5 clk1 = ~clk1;
    always @(posedge clk1) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_tol(input string tag, input int obs, input int exp, input int tol);
        int d;
        d = obs - exp;
        checks++;
        assert ((d <= tol) && (d >= -tol)) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d+/-%0d", tag, obs, exp, tol);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic clear_x();
        for (int n = 0; n < N; n++) begin
            x_re[n] = 0;
            x_im[n] = 0;
            e_re[n] = 0;
            e_im[n] = 0;
        end
    endtask

    // Mode inputs are driven to the opposite value after beat 0 so that
    // only the first-beat sample can decide the frame's mode.
    task automatic send(input logic inv, input logic scl);
        int g;
        g = 0;
        while (!in_ready && g < 1000) begin
            tick();
            g++;
        end
        chk("send in_ready", int'(in_ready), 1);
        for (int n = 0; n < N; n++) begin
            in_valid = 1'b1;
            in_re    = DW'(x_re[n]);
            in_im    = DW'(x_im[n]);
            inverse  = (n == 0) ? inv : ~inv;
            scale    = (n == 0) ? scl : ~scl;
            tick();
        end
        t_last   = cyc;
        in_valid = 1'b0;
        in_re    = '0;
        in_im    = '0;
    endtask

    task automatic wait_out(input string tag);
        int g;
        g = 0;
        while (!out_valid && g < 3000) begin
            tick();
            g++;
        end
        chk({tag, " latency"}, out_valid ? (cyc - t_last) : -1, LAT);
    endtask

    task automatic recv(input string tag, input bit rand_rdy, input bit poke_in);
        int  k, g, p_re, p_im, p_idx;
        bit  stalled, done, rdy;
        k = 0; g = 0; stalled = 0; done = 0;
        p_re = 0; p_im = 0; p_idx = 0;
        while (!done && g < 3000) begin
            if (poke_in) begin
                in_valid = 1'b1;
                in_re    = 8'sd99;
                in_im    = -8'sd99;
                chk({tag, " in_ready in unload"}, int'(in_ready), 0);
            end
            if (out_valid) begin
                if (stalled) begin
                    chk({tag, " hold re"}, int'(out_re), p_re);
                    chk({tag, " hold im"}, int'(out_im), p_im);
                    chk({tag, " hold idx"}, int'(out_idx), p_idx);
                end
                chk($sformatf("%s idx k%0d", tag, k), int'(out_idx), k);
                chk($sformatf("%s last k%0d", tag, k), int'(out_last), int'(k == N - 1));
                rdy = rand_rdy ? bit'($urandom_range(0, 1)) : 1'b1;
                out_ready = rdy;
                if (rdy) begin
                    got_re[k] = int'(out_re);
                    got_im[k] = int'(out_im);
                    if (k == N - 1) done = 1;
                    k++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    p_re  = int'(out_re);
                    p_im  = int'(out_im);
                    p_idx = int'(out_idx);
                end
            end else begin
                chk({tag, " out_valid in unload"}, int'(out_valid), 1);
                out_ready = 1'b0;
            end
            tick();
            g++;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_re     = '0;
        in_im     = '0;
        chk({tag, " frame done"}, int'(done), 1);
        chk({tag, " out_valid after last"}, int'(out_valid), 0);
        chk({tag, " in_ready after last"}, int'(in_ready), 1);
    endtask

    task automatic check_spec(input string tag, input int tol);
        for (int k = 0; k < N; k++) begin
            chk_tol($sformatf("%s X%0d re", tag, k), got_re[k], e_re[k], tol);
            chk_tol($sformatf("%s X%0d im", tag, k), got_im[k], e_im[k], tol);
        end
    endtask

    initial begin
        // round(64*cos(2*pi*n/32)) for n = 0..8, extended by symmetry
        cos_tab[0] = 64; cos_tab[1] = 63; cos_tab[2] = 59; cos_tab[3] = 53;
        cos_tab[4] = 45; cos_tab[5] = 36; cos_tab[6] = 24; cos_tab[7] = 12;
        cos_tab[8] = 0;
        for (int n = 9; n <= 16; n++) cos_tab[n] = -cos_tab[16 - n];
        for (int n = 17; n < N; n++) cos_tab[n] = cos_tab[N - n];

        rst = 1'b0; in_valid = 1'b0; in_re = '0; in_im = '0;
        inverse = 1'b0; scale = 1'b0; out_ready = 1'b0;
        repeat (3) tick();

        chk("rst in_ready", int'(in_ready), 1);
        chk("rst out_valid", int'(out_valid), 0);
        chk("rst out_last", int'(out_last), 0);
        chk("rst out_idx", int'(out_idx), 0);
        chk("rst out_re", int'(out_re), 0);
        chk("rst out_im", int'(out_im), 0);
        chk("rst ovf", int'(ovf), 0);
        rst = 1'b1;
        tick();
        chk("post-rst in_ready", int'(in_ready), 1);

        // Impulse
        clear_x();
        x_re[0] = 1;
        for (int k = 0; k < N; k++) e_re[k] = 1;
        send(1'b0, 1'b0);
        chk("imp in_ready in compute", int'(in_ready), 0);
        wait_out("imp");
        recv("imp", 1'b0, 1'b0);
        check_spec("imp", 0);
        chk("imp ovf", int'(ovf), 0);

        // DC, scaled
        clear_x();
        for (int n = 0; n < N; n++) x_re[n] = 64;
        e_re[0] = 64;
        send(1'b0, 1'b1);
        wait_out("dc");
        recv("dc", 1'b0, 1'b0);
        check_spec("dc", 0);
        chk("dc ovf", int'(ovf), 0);

        // Cosine at bin 1, scaled
        clear_x();
        for (int n = 0; n < N; n++) x_re[n] = cos_tab[n];
        e_re[1] = 32; e_re[N-1] = 32;
        send(1'b0, 1'b1);
        wait_out("cos");
        recv("cos", 1'b0, 1'b0);
        check_spec("cos", 2);
        chk("cos ovf", int'(ovf), 0);

        // Sine, inverse, scaled: X[1] = +32j, X[31] = -32j
        clear_x();
        for (int n = 0; n < N; n++) x_re[n] = cos_tab[(n + 24) % N];
        e_im[1] = 32; e_im[N-1] = -32;
        send(1'b1, 1'b1);
        wait_out("isin");
        recv("isin", 1'b0, 1'b0);
        check_spec("isin", 2);

        // Impulse under random backpressure, beats offered during unload
        clear_x();
        x_re[0] = 1;
        for (int k = 0; k < N; k++) e_re[k] = 1;
        send(1'b0, 1'b0);
        wait_out("bp");
        recv("bp", 1'b1, 1'b1);
        check_spec("bp", 0);

        // Overflow: all 127, unscaled
        clear_x();
        for (int n = 0; n < N; n++) x_re[n] = 127;
        e_re[0] = 127;
        send(1'b0, 1'b0);
        wait_out("ovf");
        recv("ovf", 1'b0, 1'b0);
        check_spec("ovf", 0);
        chk("ovf flag set", int'(ovf), 1);

        // Inverse of a single DC bin: flat 32, flag cleared by the new frame
        clear_x();
        x_re[0] = 32;
        for (int k = 0; k < N; k++) e_re[k] = 32;
        send(1'b1, 1'b0);
        chk("inv ovf cleared", int'(ovf), 0);
        wait_out("inv");
        recv("inv", 1'b0, 1'b0);
        check_spec("inv", 0);
        chk("inv ovf", int'(ovf), 0);

        // Reset 40 cycles into COMPUTE
        clear_x();
        x_re[0] = 1;
        send(1'b0, 1'b0);
        repeat (40) tick();
        chk("mid in_ready before rst", int'(in_ready), 0);
        rst = 1'b0;
        #1;
        chk("mid rst out_valid", int'(out_valid), 0);
        chk("mid rst in_ready", int'(in_ready), 1);
        tick();
        rst = 1'b1;
        tick();
        chk("mid post in_ready", int'(in_ready), 1);
        chk("mid post out_valid", int'(out_valid), 0);

        clear_x();
        x_re[0] = 1;
        for (int k = 0; k < N; k++) e_re[k] = 1;
        send(1'b0, 1'b0);
        wait_out("rimp");
        recv("rimp", 1'b0, 1'b0);
        check_spec("rimp", 0);
        chk("rimp ovf", int'(ovf), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
